// File: rtl/match_round_controller.sv
// rtl/match_round_controller.sv - best-of-N match sequencer: intro, timed fight, judgement, tally
module match_round_controller #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int ROUND_SECONDS = 99,
  parameter int INTRO_SECONDS = 3,
  parameter int END_SECONDS   = 3,
  parameter int WINS_TO_MATCH = 2,
  parameter int MAX_ROUNDS    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] health_1,
  input  logic [8:0] health_2,
  output logic       hp_reset,
  output logic       fight_en,
  output logic [2:0] state,
  output logic [2:0] round_num,
  output logic [6:0] timer_sec,
  output logic [1:0] wins_1,
  output logic [1:0] wins_2,
  output logic [1:0] round_result,
  output logic [1:0] match_winner
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INTRO      = 3'd1,
    S_FIGHT      = 3'd2,
    S_ROUND_END  = 3'd3,
    S_MATCH_OVER = 3'd4
  } state_t;

  localparam logic [1:0] R_NONE = 2'd0;
  localparam logic [1:0] R_P1   = 2'd1;
  localparam logic [1:0] R_P2   = 2'd2;
  localparam logic [1:0] R_DRAW = 2'd3;

  state_t        state_q, state_d;
  logic [CW-1:0] tick_cnt;
  logic          sec_tick;
  logic [8:0]    h1_q, h2_q;
  logic [6:0]    end_cnt;
  logic [1:0]    verdict;
  logic [1:0]    final_winner;

  assign sec_tick = (tick_cnt == CW'(TICKS_PER_SEC - 1));
  assign state    = state_q;

  always_comb begin
    state_d      = state_q;
    verdict      = R_NONE;
    final_winner = R_NONE;
    case (state_q)
      S_IDLE, S_MATCH_OVER: begin
        if (start) state_d = S_INTRO;
      end
      S_INTRO: begin
        if (sec_tick && timer_sec == 7'd1) state_d = S_FIGHT;
      end
      S_FIGHT: begin
        // KO outranks timeout, so a KO landing on the last tick is still a KO
        if (h1_q == 9'd0 && h2_q == 9'd0)   verdict = R_DRAW;
        else if (h2_q == 9'd0)              verdict = R_P1;
        else if (h1_q == 9'd0)              verdict = R_P2;
        else if (sec_tick && timer_sec == 7'd1) begin
          if (h1_q > h2_q)      verdict = R_P1;
          else if (h2_q > h1_q) verdict = R_P2;
          else                  verdict = R_DRAW;
        end
        if (verdict != R_NONE) state_d = S_ROUND_END;
      end
      S_ROUND_END: begin
        if (sec_tick && end_cnt == 7'd1) begin
          if (wins_1 == 2'(WINS_TO_MATCH)) begin
            state_d      = S_MATCH_OVER;
            final_winner = R_P1;
          end else if (wins_2 == 2'(WINS_TO_MATCH)) begin
            state_d      = S_MATCH_OVER;
            final_winner = R_P2;
          end else if (round_num == 3'(MAX_ROUNDS)) begin
            state_d = S_MATCH_OVER;
            if (wins_1 > wins_2)      final_winner = R_P1;
            else if (wins_2 > wins_1) final_winner = R_P2;
            else                      final_winner = R_DRAW;
          end else begin
            state_d = S_INTRO;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tick_cnt     <= '0;
      hp_reset     <= 1'b0;
      fight_en     <= 1'b0;
      round_num    <= 3'd1;
      timer_sec    <= 7'd0;
      wins_1       <= 2'd0;
      wins_2       <= 2'd0;
      round_result <= R_NONE;
      match_winner <= R_NONE;
      end_cnt      <= 7'd0;
      h1_q         <= 9'd0;
      h2_q         <= 9'd0;
    end else begin
      state_q  <= state_d;
      h1_q     <= health_1;
      h2_q     <= health_2;
      hp_reset <= (state_d == S_INTRO) && (state_q != S_INTRO);
      fight_en <= (state_d == S_FIGHT);

      // restart the second counter on entry so every state sees whole seconds
      if (state_d != state_q || sec_tick) tick_cnt <= '0;
      else                                tick_cnt <= tick_cnt + CW'(1);

      case (state_q)
        S_IDLE, S_MATCH_OVER: begin
          if (start) begin
            wins_1       <= 2'd0;
            wins_2       <= 2'd0;
            round_num    <= 3'd1;
            match_winner <= R_NONE;
            round_result <= R_NONE;
            timer_sec    <= 7'(INTRO_SECONDS);
          end
        end
        S_INTRO: begin
          if (state_d == S_FIGHT) begin
            timer_sec    <= 7'(ROUND_SECONDS);
            round_result <= R_NONE;
          end else if (sec_tick) begin
            timer_sec <= timer_sec - 7'd1;
          end
        end
        S_FIGHT: begin
          if (sec_tick) timer_sec <= timer_sec - 7'd1;
          if (verdict != R_NONE) begin
            round_result <= verdict;
            end_cnt      <= 7'(END_SECONDS);
            if (verdict == R_P1 && wins_1 != 2'd3) wins_1 <= wins_1 + 2'd1;
            if (verdict == R_P2 && wins_2 != 2'd3) wins_2 <= wins_2 + 2'd1;
          end
        end
        S_ROUND_END: begin
          if (sec_tick) end_cnt <= end_cnt - 7'd1;
          if (state_d == S_MATCH_OVER) match_winner <= final_winner;
          if (state_d == S_INTRO) begin
            round_num <= round_num + 3'd1;
            timer_sec <= 7'(INTRO_SECONDS);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_match_round_controller.sv
// tb/tb_match_round_controller.sv - directed scoreboard bench for match_round_controller
module tb_match_round_controller;

  logic       clk;
  logic       reset;
  logic       start;
  logic [8:0] health_1, health_2;
  logic       hp_reset, fight_en;
  logic [2:0] state, round_num;
  logic [6:0] timer_sec;
  logic [1:0] wins_1, wins_2, round_result, match_winner;

  int checks   = 0;
  int failures = 0;
  int n;

  typedef struct packed {
    logic [1:0] res;
    logic [1:0] w1;
    logic [1:0] w2;
    logic [2:0] rnd;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  match_round_controller #(
    .TICKS_PER_SEC(4),
    .ROUND_SECONDS(5),
    .INTRO_SECONDS(2),
    .END_SECONDS(2),
    .WINS_TO_MATCH(2),
    .MAX_ROUNDS(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .health_1(health_1),
    .health_2(health_2),
    .hp_reset(hp_reset),
    .fight_en(fight_en),
    .state(state),
    .round_num(round_num),
    .timer_sec(timer_sec),
    .wins_1(wins_1),
    .wins_2(wins_2),
    .round_result(round_result),
    .match_winner(match_winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, output int cyc);
    cyc = 0;
    while (state !== target && cyc < budget) begin
      step();
      cyc++;
    end
    chk("wait_state", {29'd0, state}, {29'd0, target});
  endtask

  // drive one round's health pattern, then score the verdict on ROUND_END entry
  task automatic play_round(input logic [8:0] h1, input logic [8:0] h2,
                            input logic [1:0] res, input logic [1:0] w1,
                            input logic [1:0] w2, input logic [2:0] rnd);
    int c;
    exp_t x;
    wait_state(3'd2, 200, c);
    health_1 = h1;
    health_2 = h2;
    sb.push_back('{res: res, w1: w1, w2: w2, rnd: rnd});
    wait_state(3'd3, 200, c);
    chk("sb_nonempty", sb.size(), (sb.size() > 0) ? sb.size() : 1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("round_result", round_result, x.res);
      chk("wins_1", wins_1, x.w1);
      chk("wins_2", wins_2, x.w2);
      chk("round_num", round_num, x.rnd);
      chk("fight_en_end", fight_en, 1'b0);
    end
    health_1 = 9'd300;
    health_2 = 9'd300;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    health_1 = 9'd300;
    health_2 = 9'd300;
    step();
    step();
    reset = 1'b0;
    chk("rst_state", state, 3'd0);
    chk("rst_hp_reset", hp_reset, 1'b0);
    chk("rst_fight_en", fight_en, 1'b0);
    chk("rst_round", round_num, 3'd1);
    chk("rst_timer", timer_sec, 7'd0);
    chk("rst_wins", {wins_1, wins_2}, 4'd0);
    chk("rst_result", round_result, 2'd0);
    chk("rst_winner", match_winner, 2'd0);

    // start from IDLE: intro of two seconds, fight 8 cycles after entry
    start = 1'b1;
    step();
    start = 1'b0;
    chk("intro_state", state, 3'd1);
    chk("intro_hp_reset", hp_reset, 1'b1);
    chk("intro_timer", timer_sec, 7'd2);
    step();
    chk("hp_reset_drop", hp_reset, 1'b0);
    for (int i = 0; i < 6; i++) step();
    chk("intro_last_state", state, 3'd1);
    chk("intro_last_timer", timer_sec, 7'd1);
    step();
    chk("fight_state", state, 3'd2);
    chk("fight_en", fight_en, 1'b1);
    chk("fight_timer", timer_sec, 7'd5);

    // P1 takes the match with two KOs
    play_round(9'd300, 9'd0, 2'd1, 2'd1, 2'd0, 3'd1);
    wait_state(3'd1, 200, n);
    chk("r2_round", round_num, 3'd2);
    chk("r2_hp_reset", hp_reset, 1'b1);
    chk("r2_result_held", round_result, 2'd1);
    play_round(9'd300, 9'd0, 2'd1, 2'd2, 2'd0, 3'd2);
    wait_state(3'd4, 200, n);
    chk("end_hold_cycles", n, 8);
    chk("mo_winner", match_winner, 2'd1);
    chk("mo_wins_1", wins_1, 2'd2);
    chk("mo_round", round_num, 3'd2);

    // restart from MATCH_OVER
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_state", state, 3'd1);
    chk("restart_wins", {wins_1, wins_2}, 4'd0);
    chk("restart_round", round_num, 3'd1);
    chk("restart_winner", match_winner, 2'd0);

    // timeout with P1 ahead: ROUND_END 20 cycles into FIGHT, clock at 0
    wait_state(3'd2, 200, n);
    health_1 = 9'd300;
    health_2 = 9'd120;
    sb.push_back('{res: 2'd1, w1: 2'd1, w2: 2'd0, rnd: 3'd1});
    wait_state(3'd3, 200, n);
    chk("timeout_cycles", n, 20);
    chk("timeout_timer", timer_sec, 7'd0);
    e = sb.pop_front();
    chk("to_result", round_result, e.res);
    chk("to_wins", {wins_1, wins_2}, {e.w1, e.w2});
    health_1 = 9'd300;
    health_2 = 9'd300;

    play_round(9'd100, 9'd200, 2'd2, 2'd1, 2'd1, 3'd2);
    play_round(9'd0,   9'd0,   2'd3, 2'd1, 2'd1, 3'd3);
    play_round(9'd150, 9'd150, 2'd3, 2'd1, 2'd1, 3'd4);
    play_round(9'd0,   9'd50,  2'd2, 2'd1, 2'd2, 3'd5);
    wait_state(3'd4, 200, n);
    chk("p2_match_winner", match_winner, 2'd2);

    // five double KOs reach MAX_ROUNDS with a drawn match
    start = 1'b1;
    step();
    start = 1'b0;
    play_round(9'd0, 9'd0, 2'd3, 2'd0, 2'd0, 3'd1);
    wait_state(3'd1, 200, n);
    chk("draw_round_adv", round_num, 3'd2);
    for (int r = 2; r <= 5; r++) play_round(9'd0, 9'd0, 2'd3, 2'd0, 2'd0, 3'(r));
    wait_state(3'd4, 200, n);
    chk("draw_match_winner", match_winner, 2'd3);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("draw_restart_state", state, 3'd1);
    chk("draw_restart_wins", {wins_1, wins_2}, 4'd0);

    // reset mid-FIGHT after a round has been scored
    play_round(9'd300, 9'd0, 2'd1, 2'd1, 2'd0, 3'd1);
    wait_state(3'd2, 200, n);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_state", state, 3'd0);
    chk("midrst_fight_en", fight_en, 1'b0);
    chk("midrst_wins", {wins_1, wins_2}, 4'd0);
    chk("midrst_round", round_num, 3'd1);
    chk("midrst_hp_reset", hp_reset, 1'b0);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
